// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the Avalon load/store unit.
package lsu_pkg;

    typedef enum logic [3:0] {
        OP_LB,
        OP_LBU,
        OP_LH,
        OP_LHU,
        OP_LW,
        OP_LWL,
        OP_LWR,
        OP_SB,
        OP_SH,
        OP_SW
    } lsu_op_t;

    typedef enum logic [1:0] {
        ERR_OK         = 2'd0,
        ERR_MISALIGNED = 2'd1,
        ERR_TIMEOUT    = 2'd2
    } lsu_err_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_RESP
    } lsu_state_t;

    function automatic logic is_store(lsu_op_t op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    // LWL/LWR exist precisely to handle unaligned words, so they never trap.
    function automatic logic is_misaligned(lsu_op_t op, logic [1:0] addr_lo);
        if (op inside {OP_LH, OP_LHU, OP_SH}) return addr_lo[0];
        if (op inside {OP_LW, OP_SW})         return addr_lo != 2'b00;
        return 1'b0;
    endfunction

endpackage

// File: rtl/lsu_load_format.sv
// Combinational load result formatting: byte/half select, extension and
// the MIPS LWL/LWR merge with the old rt value.
module lsu_load_format
    import lsu_pkg::*;
(
    input  logic [31:0] lane_i,
    input  logic [1:0]  b_i,
    input  lsu_op_t     op_i,
    input  logic [31:0] rt_i,
    output logic [31:0] result_o
);

    logic [4:0]  sh_r;
    logic [4:0]  sh_l;
    logic [31:0] shr;

    always_comb begin
        // NOTE: every output gets a value before the case so no path leaves it unassigned (no latch).
        result_o = lane_i;
        sh_r     = {b_i, 3'b000};
        sh_l     = {~b_i, 3'b000};
        shr      = lane_i >> sh_r;
        case (op_i)
            OP_LB:   result_o = {{24{shr[7]}}, shr[7:0]};
            OP_LBU:  result_o = {24'h0, shr[7:0]};
            OP_LH:   result_o = {{16{shr[15]}}, shr[15:0]};
            OP_LHU:  result_o = {16'h0, shr[15:0]};
            OP_LWL:  result_o = (lane_i << sh_l) | (rt_i & (32'h00FF_FFFF >> sh_r));
            OP_LWR:  result_o = shr | (rt_i & ~(32'hFFFF_FFFF >> sh_r));
            default: result_o = lane_i;
        endcase
    end

endmodule

// File: rtl/avalon_lsu.sv
// Single-outstanding load/store unit bridging the core to an Avalon-MM master,
// with alignment checking and a waitrequest timeout.
module avalon_lsu
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 256
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  lsu_op_t                   req_op,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [31:0]               req_wdata,
    input  logic [31:0]               req_rt,
    output logic                      resp_valid,
    output logic [31:0]               resp_data,
    output logic [1:0]                resp_err,
    output logic [ADDR_WIDTH-1:0]     address,
    output logic                      read,
    output logic                      write,
    input  logic                      waitrequest,
    output logic [DATA_WIDTH-1:0]     writedata,
    output logic [DATA_WIDTH/8-1:0]   byteenable,
    input  logic [DATA_WIDTH-1:0]     readdata
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
        $error("avalon_lsu: DATA_WIDTH must be 32 or 64");
    end

    lsu_state_t            state_q;
    lsu_op_t               op_q;
    logic [OFF_W-1:0]      off_q;
    logic [31:0]           rt_q;
    logic [ADDR_WIDTH-1:0] address_q;
    logic [BE_W-1:0]       be_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  read_q;
    logic                  write_q;
    logic                  resp_valid_q;
    lsu_err_t              resp_err_q;
    logic [31:0]           resp_data_q;
    logic [CNT_W-1:0]      stall_q;

    logic [OFF_W-1:0]      req_off;
    logic [OFF_W-1:0]      be_shift;
    logic [3:0]            be_base;
    logic [BE_W-1:0]       be_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic [OFF_W+2:0]      lane_shift;
    logic [31:0]           lane;
    logic [31:0]           load_result;
    logic                  accept;

    assign accept = (state_q == ST_IDLE) && req_valid;

    // Loads always fetch the whole 32-bit lane; stores enable only their bytes.
    always_comb begin
        req_off  = req_addr[OFF_W-1:0];
        be_base  = 4'hF;
        be_shift = req_off & ~OFF_W'(3);
        case (req_op)
            OP_SB:   begin be_base = 4'h1; be_shift = req_off; end
            OP_SH:   begin be_base = 4'h3; be_shift = req_off; end
            OP_SW:   begin be_base = 4'hF; be_shift = req_off; end
            default: ;
        endcase
        be_d    = BE_W'(be_base) << be_shift;
        wdata_d = DATA_WIDTH'(req_wdata) << {req_off, 3'b000};
    end

    always_comb begin
        lane_shift = {off_q & ~OFF_W'(3), 3'b000};
        lane       = 32'(readdata >> lane_shift);
    end

    lsu_load_format u_fmt (
        .lane_i   (lane),
        .b_i      (off_q[1:0]),
        .op_i     (op_q),
        .rt_i     (rt_q),
        .result_o (load_result)
    );

    // NOTE: pure datapath registers carry no reset; the FSM never lets their stale contents escape.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q      <= req_op;
            off_q     <= req_off;
            rt_q      <= req_rt;
            address_q <= req_addr & ~ADDR_WIDTH'(BE_W - 1);
            be_q      <= be_d;
            wdata_q   <= wdata_d;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= ERR_OK;
            resp_data_q  <= '0;
            stall_q      <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        stall_q <= '0;
                        if (is_misaligned(req_op, req_addr[1:0])) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= ERR_MISALIGNED;
                            resp_data_q  <= '0;
                        end else begin
                            state_q <= ST_BUS;
                            read_q  <= !is_store(req_op);
                            write_q <= is_store(req_op);
                        end
                    end
                end
                ST_BUS: begin
                    if (!waitrequest) begin
                        state_q      <= ST_RESP;
                        read_q       <= 1'b0;
                        write_q      <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= ERR_OK;
                        resp_data_q  <= is_store(op_q) ? 32'h0 : load_result;
                    end else if (TIMEOUT != 0 && 32'(stall_q) == TIMEOUT - 1) begin
                        state_q      <= ST_RESP;
                        read_q       <= 1'b0;
                        write_q      <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= ERR_TIMEOUT;
                        resp_data_q  <= '0;
                    end else begin
                        stall_q <= stall_q + 1'b1;
                    end
                end
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign address    = address_q;
    assign read       = read_q;
    assign write      = write_q;
    assign writedata  = wdata_q;
    assign byteenable = be_q;

endmodule

// File: tb/tb_avalon_lsu.sv
// Runs a 32-bit and a 64-bit LSU in lockstep against a byte-level reference model.
module tb_avalon_lsu;
    import lsu_pkg::*;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    lsu_op_t     req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_rt;
    logic        waitrequest;
    logic [63:0] readdata;

    logic        rdy32, rv32, rd32, wr32;
    logic [1:0]  err32;
    logic [31:0] data32, addr32, wd32;
    logic [3:0]  be32;

    logic        rdy64, rv64, rd64, wr64;
    logic [1:0]  err64;
    logic [31:0] data64, addr64;
    logic [63:0] wd64;
    logic [7:0]  be64;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    avalon_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(TMO)) dut32 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy32),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .req_rt(req_rt),
        .resp_valid(rv32), .resp_data(data32), .resp_err(err32),
        .address(addr32), .read(rd32), .write(wr32), .waitrequest(waitrequest),
        .writedata(wd32), .byteenable(be32), .readdata(readdata[31:0])
    );

    avalon_lsu #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT(TMO)) dut64 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy64),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .req_rt(req_rt),
        .resp_valid(rv64), .resp_data(data64), .resp_err(err64),
        .address(addr64), .read(rd64), .write(wr64), .waitrequest(waitrequest),
        .writedata(wd64), .byteenable(be64), .readdata(readdata)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_store(input lsu_op_t op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic int unsigned model_size(input lsu_op_t op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            default:              return 4;
        endcase
    endfunction

    function automatic bit model_misaligned(input lsu_op_t op, input logic [31:0] addr);
        if (op == OP_LWL || op == OP_LWR) return 1'b0;
        return (addr % model_size(op)) != 0;
    endfunction

    // Byte-lane view of the bus: which bytes move and where the store bytes land.
    task automatic model_bus(input lsu_op_t op, input logic [31:0] addr, input logic [31:0] wdata,
                             input int unsigned nb, output logic [31:0] e_addr,
                             output logic [7:0] e_be, output logic [63:0] e_wd);
        int unsigned o, first, size;
        o     = addr % nb;
        size  = model_store(op) ? model_size(op) : 4;
        first = model_store(op) ? o : o - (o % 4);
        e_addr = addr - o;
        e_be   = '0;
        e_wd   = '0;
        for (int i = 0; i < int'(size); i++) e_be[first + i] = 1'b1;
        for (int j = 0; j < 4; j++)
            if (o + j < nb) e_wd[8*(o + j) +: 8] = wdata[8*j +: 8];
    endtask

    function automatic logic [31:0] model_load(input lsu_op_t op, input logic [31:0] addr,
                                               input logic [63:0] rd, input int unsigned nb,
                                               input logic [31:0] rt);
        logic [7:0] w [4];
        logic [7:0] r [4];
        int unsigned o, base, b;
        o    = addr % nb;
        base = o - (o % 4);
        b    = addr % 4;
        for (int i = 0; i < 4; i++) begin
            w[i] = rd[8*(base + i) +: 8];
            r[i] = rt[8*i +: 8];
        end
        case (op)
            OP_LB:  return {{24{w[b][7]}}, w[b]};
            OP_LBU: return {24'h0, w[b]};
            OP_LH:  return {{16{w[b+1][7]}}, w[b+1], w[b]};
            OP_LHU: return {16'h0, w[b+1], w[b]};
            OP_LW:  return {w[3], w[2], w[1], w[0]};
            OP_LWL: begin
                for (int k = 0; k <= int'(b); k++) r[3 - b + k] = w[k];
                return {r[3], r[2], r[1], r[0]};
            end
            OP_LWR: begin
                for (int k = int'(b); k < 4; k++) r[k - b] = w[k];
                return {r[3], r[2], r[1], r[0]};
            end
            default: return 32'h0;
        endcase
    endfunction

    task automatic run_txn(input lsu_op_t op, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rt, input logic [63:0] rd, input int stalls);
        bit          mis, store, tmo;
        int          nbus;
        logic [31:0] ea32, ea64;
        logic [7:0]  eb32, eb64;
        logic [63:0] ew32, ew64;
        logic [1:0]  eerr;
        store = model_store(op);
        mis   = model_misaligned(op, addr);
        tmo   = !mis && stalls >= TMO;
        nbus  = tmo ? TMO : stalls + 1;
        eerr  = mis ? 2'd1 : (tmo ? 2'd2 : 2'd0);
        model_bus(op, addr, wdata, 4, ea32, eb32, ew32);
        model_bus(op, addr, wdata, 8, ea64, eb64, ew64);

        @(negedge clk);
        check("ready32_idle", rdy32, 1'b1);
        check("ready64_idle", rdy64, 1'b1);
        req_valid = 1'b1; req_op = op; req_addr = addr;
        req_wdata = wdata; req_rt = rt; readdata = rd; waitrequest = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        if (!mis) begin
            for (int c = 1; c <= nbus; c++) begin
                check("read32",  rd32, !store);
                check("write32", wr32, store);
                check("read64",  rd64, !store);
                check("write64", wr64, store);
                check("addr32",  addr32, ea32);
                check("addr64",  addr64, ea64);
                check("be32",    be32, eb32[3:0]);
                check("be64",    be64, eb64);
                if (store) begin
                    check("wd32", wd32, ew32[31:0]);
                    check("wd64", wd64, ew64);
                end
                check("busy_rv32",  rv32, 1'b0);
                check("busy_rdy64", rdy64, 1'b0);
                waitrequest = (c <= stalls);
                @(negedge clk);
            end
        end
        check("rv32",   rv32, 1'b1);
        check("rv64",   rv64, 1'b1);
        check("err32",  err32, eerr);
        check("err64",  err64, eerr);
        check("data32", data32, (mis || tmo || store) ? 32'h0 : model_load(op, addr, rd, 4, rt));
        check("data64", data64, (mis || tmo || store) ? 32'h0 : model_load(op, addr, rd, 8, rt));
        check("resp_rd32", rd32 | wr32, 1'b0);
        check("resp_rd64", rd64 | wr64, 1'b0);
        @(negedge clk);
        check("pulse32", rv32, 1'b0);
        check("pulse64", rv64, 1'b0);
        check("back_rdy32", rdy32, 1'b1);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_op = OP_LW; req_addr = '0;
        req_wdata = '0; req_rt = '0; waitrequest = 1'b0; readdata = '0;
        repeat (2) @(negedge clk);
        check("rst_read32",  rd32, 1'b0);
        check("rst_write64", wr64, 1'b0);
        check("rst_rv32",    rv32, 1'b0);
        check("rst_err64",   err64, 2'd0);
        check("rst_data32",  data32, 32'h0);
        check("rst_rdy64",   rdy64, 1'b1);
        reset = 1'b0;

        run_txn(OP_LW,  32'h1000, 32'h0, 32'h0, 64'hDEADBEEF, 0);
        run_txn(OP_LB,  32'h1003, 32'h0, 32'h0, 64'h80112233, 0);
        run_txn(OP_LBU, 32'h1003, 32'h0, 32'h0, 64'h80112233, 1);
        run_txn(OP_SH,  32'h1002, 32'h0000ABCD, 32'h0, 64'h0, 3);
        run_txn(OP_LWL, 32'h1001, 32'h0, 32'hAABBCCDD, 64'h44332211, 0);
        run_txn(OP_LWR, 32'h1001, 32'h0, 32'hAABBCCDD, 64'h44332211, 0);
        run_txn(OP_LWL, 32'h1003, 32'h0, 32'hAABBCCDD, 64'h44332211, 0);
        run_txn(OP_LWR, 32'h1000, 32'h0, 32'hAABBCCDD, 64'h44332211, 0);
        run_txn(OP_LW,  32'h1002, 32'h0, 32'h0, 64'h0, 0);
        run_txn(OP_LW,  32'h1000, 32'h0, 32'h0, 64'h0, 10);
        run_txn(OP_SW,  32'h2004, 32'h12345678, 32'h0, 64'h0, 0);
        run_txn(OP_LH,  32'h2006, 32'h0, 32'h0, 64'h8765_4321_0000_0000, 2);

        // Reset during a stalled read abandons it silently.
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h3000; waitrequest = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("mid_read32", rd32, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_read32", rd32, 1'b0);
        check("mid_rst_read64", rd64, 1'b0);
        check("mid_rst_rdy32",  rdy32, 1'b1);
        check("mid_rst_rv64",   rv64, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("no_resp32", rv32, 1'b0);
        end
        waitrequest = 1'b0;

        for (int n = 0; n < 80; n++) begin
            lsu_op_t     op;
            int          st;
            op = lsu_op_t'($urandom_range(0, 9));
            st = ($urandom_range(0, 9) == 0) ? $urandom_range(TMO, TMO + 2) : $urandom_range(0, 3);
            run_txn(op, $urandom, $urandom, $urandom, {$urandom, $urandom}, st);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/avalon_lsu.md
Name: avalon_lsu

Overview:
- Parametrised load/store unit between the multicycle MIPS core datapath and the Avalon-MM master port.
- Accepts one memory operation at a time from the core, drives address/read/write/byteenable/writedata, and honours waitrequest.
- Returns the aligned and extended load result, including the LWL/LWR merge.
- Adds what the inline bus logic in the core lacks: a 64-bit bus option, alignment-exception detection, and a waitrequest timeout with an error response.

Parameters:
- DATA_WIDTH, 32, Avalon data width. Legal values are 32 or 64; any other value is an elaboration error.
- ADDR_WIDTH, 32, byte address width.
- TIMEOUT, 256, maximum cycles a request may stall on waitrequest. 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  core presents an operation
- req_ready  out  1  LSU can accept (high only in IDLE)
- req_op  in  4  lsu_op_t (LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW)
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  32  store data (rt)
- req_rt  in  32  old rt value, used by the LWL/LWR merge
- resp_valid  out  1  one-cycle pulse, result or error
- resp_data  out  32  load result (0 for stores and errors)
- resp_err  out  2  0 OK, 1 misaligned, 2 timeout
- address  out  ADDR_WIDTH  bus address, aligned to DATA_WIDTH/8
- read  out  1  Avalon read
- write  out  1  Avalon write
- waitrequest  in  1  slave stall
- writedata  out  DATA_WIDTH  lane-shifted store data
- byteenable  out  DATA_WIDTH/8  active byte lanes
- readdata  in  DATA_WIDTH  valid in the cycle waitrequest is low with read high

Behaviour:
- State machine states: IDLE, BUS, RESP.
- On reset, from any state: go to IDLE. read, write, resp_valid, resp_err and resp_data all reset to 0. Any in-flight bus transaction is abandoned with no response.
- IDLE:
  - req_ready=1.
  - On req_valid, latch op, addr, wdata and rt.
  - Alignment rule: misaligned if (LH/LHU/SH and addr[0]) or (LW/SW and addr[1:0]!=0).
  - Misaligned request: go to RESP with err=1 and issue no bus cycle.
  - Aligned request: go to BUS.
- BUS:
  - read is high for loads, write is high for stores. address, byteenable and writedata are registered and held stable while waitrequest=1.
  - Little-endian lanes. The byte offset within the bus word is o = addr[log2(DATA_WIDTH/8)-1:0].
  - byteenable: SB = 1<<o; SH = 3<<o; SW = 4'hF<<o. LW, LWL, LWR and all loads enable the full 32-bit lane: 4'hF<<(o & ~3).
  - writedata = store data shifted left by 8*o.
  - Transaction completes in the first cycle with waitrequest=0. Capture the selected lane of readdata and go to RESP. Minimum bus occupancy is 1 cycle.
  - Stall counter increments each waitrequest=1 cycle. If TIMEOUT!=0 and the count reaches TIMEOUT: drop read/write in the next cycle, go to RESP with err=2. Completion and timeout in the same cycle resolve as completion.
- RESP:
  - resp_valid=1 for exactly one cycle, then return to IDLE.
  - Total latency from accept to resp_valid: 2 + number of stall cycles. Misaligned requests respond after 1 cycle.
- Load formatting (w = 32-bit lane, b = byte offset within the lane):
  - LB and LH sign-extend; LBU and LHU zero-extend; LW returns w.
  - LWL: result = (w << 8*(3-b)) | (rt & (2^(8*(3-b)) - 1)). At b=3 the result is the whole word w.
  - LWR: result = (w >> 8*b) | (rt & ~(2^(32-8*b) - 1)). At b=0 the result is w.
- req_valid while not in IDLE is ignored. The core must hold off until it sees req_ready.

Decomposition:
- Package lsu_pkg holds:
  - lsu_op_t enum (4 bits)
  - lsu_err_t enum (OK, MISALIGNED, TIMEOUT)
  - helper functions is_store(op) and is_misaligned(op, addr)
- Sub-module lsu_load_format: purely combinational lane select, extension and LWL/LWR merge. Inputs: lane, b, op, rt. Output: result.
- The FSM, stall counter and bus registers remain in avalon_lsu.

Test Plan:
- LW at 0x1000, DATA_WIDTH=32, waitrequest low, readdata=0xDEADBEEF -> read=1 for 1 cycle, byteenable=0xF, resp_valid 2 cycles after accept, resp_data=0xDEADBEEF, resp_err=0.
- LB at 0x1003, readdata=0x80112233 -> byteenable=0xF, resp_data=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH at 0x1002 with req_wdata=0x0000ABCD, waitrequest high for 3 cycles -> write held 4 cycles, address=0x1000, byteenable=0xC, writedata=0xABCD0000 stable throughout; resp_valid 5 cycles after accept.
- LWL at 0x1001, readdata=0x44332211, rt=0xAABBCCDD -> 0x2211CCDD. LWR at 0x1001, same data -> 0xAA443322.
- LW at 0x1002 -> no read asserted, resp_err=1 one cycle after accept. TIMEOUT=4 with waitrequest stuck high -> read high for 4 cycles then dropped, resp_err=2.
- DATA_WIDTH=64: SW at 0x2004 with 0x12345678 -> address=0x2000, byteenable=0xF0, writedata[63:32]=0x12345678. Reset asserted mid-BUS -> read=0 next cycle, no resp_valid, req_ready=1.
